// File: rtl/model_if_pkg.sv
// Shared definitions for the memory-model test loop interfaces (model2axis_if and axis2model_if).
// Holds the header framing constants, header field positions, the transmit FSM state type and a
// helper that assembles a response header word.
package model_if_pkg;

  // Header framing: bit31 marks the first word of every packet in both directions.
  localparam int unsigned HDR_FLAG = 31;
  localparam logic [6:0]  RESP_TAG = 7'h20;

  // Header field positions and widths.
  localparam int unsigned HDR_TAG_LSB = 24;
  localparam int unsigned HDR_TAG_W   = 7;
  localparam int unsigned HDR_SEQ_LSB = 16;
  localparam int unsigned HDR_SEQ_W   = 8;
  localparam int unsigned HDR_LEN_LSB = 0;
  localparam int unsigned HDR_LEN_W   = 8;

  typedef enum logic [1:0] {
    StIdle,
    StHeader,
    StPayload
  } tx_state_e;

  // {1'b1, RESP_TAG, seq, 8'h00, len}
  function automatic logic [31:0] make_resp_header(input logic [HDR_SEQ_W-1:0] seq,
                                                   input logic [HDR_LEN_W-1:0] len);
    logic [31:0] hdr;
    hdr = '0;
    hdr[HDR_FLAG] = 1'b1;
    hdr[HDR_TAG_LSB +: HDR_TAG_W] = RESP_TAG;
    hdr[HDR_SEQ_LSB +: HDR_SEQ_W] = seq;
    hdr[HDR_LEN_LSB +: HDR_LEN_W] = len;
    return hdr;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// Synchronous first-word-fall-through FIFO for DUT result words.
// Ports:
//   clk_i, rst_ni       clock and synchronous active-low reset
//   wr_en_i, wr_data_i  push request and data; ignored while full
//   rd_en_i             pop request; ignored while empty
//   rd_data_o           current head word, valid whenever empty_o is low
//   count_o             number of stored words (registered)
//   full_o, empty_o     flags derived from the registered count
// DEPTH must be a power of two so the pointers wrap naturally.
module resp_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         wr_en_i,
  input  logic [WIDTH-1:0]             wr_data_i,
  input  logic                         rd_en_i,
  output logic [WIDTH-1:0]             rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o    = (count_q == CntW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign do_push   = wr_en_i & ~full_o;
  assign do_pop    = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/model2axis_if.sv
// Return-path transmitter: buffers DUT result words and emits them as framed AXI-Stream packets
// (one header word, then 1..MAX_BURST payload words, tlast on the final word).
// Ports:
//   core_clk, rst_n       clock and synchronous active-low reset
//   dut_data, dut_valid   result words from the DUT, no backpressure
//   flush                 forces emission of everything buffered (ignored when empty or busy)
//   core2gtp_t*           AXI-Stream master toward the GTP link
//   overflow, drop_cnt    sticky drop flag and saturating drop counter
//   tx_busy               FSM is sending a packet
module model2axis_if
  import model_if_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 64,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned IDLE_TIMEOUT = 64
) (
  input  logic        core_clk,
  input  logic        rst_n,
  input  logic [31:0] dut_data,
  input  logic        dut_valid,
  input  logic        flush,
  output logic [31:0] core2gtp_tdata,
  output logic        core2gtp_tvalid,
  input  logic        core2gtp_tready,
  output logic        core2gtp_tlast,
  output logic        overflow,
  output logic [15:0] drop_cnt,
  output logic        tx_busy
);

  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IdleW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CntW-1:0]  BurstMax  = CntW'(MAX_BURST);
  localparam logic [7:0]       BurstMax8 = 8'(MAX_BURST);
  localparam logic [IdleW-1:0] IdleMax   = IdleW'(IDLE_TIMEOUT);

  logic [31:0]     fifo_rdata;
  logic [CntW-1:0] fifo_count;
  logic            fifo_full, fifo_empty, fifo_pop;

  tx_state_e        state_q, state_d;
  logic [7:0]       seq_q, seq_d;
  logic [7:0]       burst_len_q, burst_len_d;
  logic [7:0]       rem_q, rem_d;
  logic [31:0]      hdr_q, hdr_d;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic             overflow_q;
  logic [15:0]      drop_cnt_q;
  logic             start;
  logic             drop;

  resp_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk_i     (core_clk),
    .rst_ni    (rst_n),
    .wr_en_i   (dut_valid),
    .wr_data_i (dut_data),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_rdata),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Registered full flag: a same-cycle pop never makes room for this push.
  assign drop = dut_valid & fifo_full;

  assign start = (fifo_count >= BurstMax) ||
                 (!fifo_empty && ((idle_cnt_q == IdleMax) || flush));

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (dut_valid || fifo_empty || (state_q != StIdle)) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IdleMax) begin
      idle_cnt_d = idle_cnt_q + IdleW'(1);
    end
  end

  always_comb begin
    state_d         = state_q;
    seq_d           = seq_q;
    burst_len_d     = burst_len_q;
    rem_d           = rem_q;
    hdr_d           = hdr_q;
    fifo_pop        = 1'b0;
    core2gtp_tvalid = 1'b0;
    core2gtp_tdata  = '0;
    core2gtp_tlast  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StHeader;
          burst_len_d = (fifo_count >= BurstMax) ? BurstMax8 : 8'(fifo_count);
          hdr_d       = make_resp_header(seq_q, burst_len_d);
        end
      end
      StHeader: begin
        core2gtp_tvalid = 1'b1;
        core2gtp_tdata  = hdr_q;
        if (core2gtp_tready) begin
          state_d = StPayload;
          rem_d   = burst_len_q;
        end
      end
      StPayload: begin
        // FWFT head stays put until accepted; later pushes only touch the tail.
        core2gtp_tvalid = 1'b1;
        core2gtp_tdata  = fifo_rdata;
        core2gtp_tlast  = (rem_q == 8'd1);
        if (core2gtp_tready) begin
          fifo_pop = 1'b1;
          rem_d    = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            seq_d   = seq_q + 8'd1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      seq_q       <= '0;
      burst_len_q <= '0;
      rem_q       <= '0;
      hdr_q       <= '0;
      idle_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      burst_len_q <= burst_len_d;
      rem_q       <= rem_d;
      hdr_q       <= hdr_d;
      idle_cnt_q  <= idle_cnt_d;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
  assign tx_busy  = (state_q != StIdle);

endmodule
